// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port RAM with one write port and one read port,
// a registered read with a valid strobe, and a hardware clear engine that
// sweeps every entry to CLEAR_VALUE while reporting busy / clear_done.
//
// Optional build macro: RAM_SDP_CLR_PARITY_EN
//   Adds an even-parity bit to every entry, a parity_err read flag and an
//   inj_err write-side fault injection input.
module ram_sdp_clr #(
  parameter int               WIDTH       = 8,
  parameter int               ADDR_W      = 6,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clear,
  output logic              busy,
  output logic              clear_done
`ifdef RAM_SDP_CLR_PARITY_EN
  ,
  output logic              parity_err,
  input  logic              inj_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RAM_SDP_CLR_PARITY_EN
  // Data in the low WIDTH bits, even parity in the top bit.
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Storage: never reset, only written through the single write port.
  logic [MW-1:0] mem [DEPTH];

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0]  rd_data_q,    rd_data_d;
  logic              rd_valid_q,   rd_valid_d;
  logic              clear_done_q, clear_done_d;
`ifdef RAM_SDP_CLR_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  // Array port signals after arbitration between the sweep and user traffic.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_rword;

  // User traffic is accepted only when idle and no clear is being requested;
  // a clear request in the same cycle wins and the access is dropped.
  logic user_ok;
  assign user_ok = (state_q == IDLE) && !clear;

  // Asynchronous array read of the current address; sampled into rd_data_q
  // at the edge, which gives read-first behaviour against a same-cycle write.
  always_comb begin
    mem_rword = mem[rd_addr];
  end

  // Clear engine: IDLE accepts a request, SWEEP walks cnt over every entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST_ADDR) begin
          state_d      = IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Write-port arbitration: the sweep owns the port while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
`ifdef RAM_SDP_CLR_PARITY_EN
    mem_wdata = {(^wr_data) ^ inj_err, wr_data};
`else
    mem_wdata = wr_data;
`endif
    if (state_q == SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
`ifdef RAM_SDP_CLR_PARITY_EN
      mem_wdata = {^CLEAR_VALUE, CLEAR_VALUE};
`else
      mem_wdata = CLEAR_VALUE;
`endif
    end else if (user_ok && wr_en) begin
      mem_we = 1'b1;
    end
  end

  // Read-side next state: capture on an accepted read, otherwise hold data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`ifdef RAM_SDP_CLR_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (user_ok && rd_en) begin
      rd_data_d  = mem_rword[WIDTH-1:0];
      rd_valid_d = 1'b1;
`ifdef RAM_SDP_CLR_PARITY_EN
      parity_err_d = mem_rword[WIDTH] ^ (^mem_rword[WIDTH-1:0]);
`endif
    end
  end

  // Array write; reset suppresses the write so an aborted sweep stops cleanly.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control and read registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      clear_done_q <= 1'b0;
`ifdef RAM_SDP_CLR_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      clear_done_q <= clear_done_d;
`ifdef RAM_SDP_CLR_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == SWEEP);
  assign clear_done = clear_done_q;
`ifdef RAM_SDP_CLR_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Self-checking bench for ram_sdp_clr (WIDTH=8, ADDR_W=6, CLEAR_VALUE=0).
// Reads are scored through a queue of expected data filled when the read is
// driven and drained when rd_valid appears.
module tb_ram_sdp_clr;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clear;
  logic       busy;
  logic       clear_done;
`ifdef RAM_SDP_CLR_PARITY_EN
  logic       parity_err;
  logic       inj_err;
`endif

  ram_sdp_clr #(.WIDTH(8), .ADDR_W(6), .CLEAR_VALUE(8'h00)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear      (clear),
    .busy       (busy),
    .clear_done (clear_done)
`ifdef RAM_SDP_CLR_PARITY_EN
    ,
    .parity_err (parity_err),
    .inj_err    (inj_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [5:0] ra;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_mem [64];
  logic [7:0] sb_q [$];
  vec_t       tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Compare a returned read against the oldest queued expectation.
  task automatic score(input string nm);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%0h required=<no read outstanding>", nm, rd_data);
    end else begin
      chk(nm, 32'(rd_data), 32'(sb_q.pop_front()));
    end
  endtask

  // One idle cycle of user traffic, expectations taken from the model array.
  task automatic step(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                      input logic re, input logic [5:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clear = 1'b0;
    if (re) sb_q.push_back(exp_mem[ra]);
    if (we) exp_mem[wa] = wd;
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (re) begin
      chk("step_rd_valid", 32'(rd_valid), 32'(1));
      if (rd_valid) score("step_rd_data");
`ifdef RAM_SDP_CLR_PARITY_EN
      chk("step_parity_err", 32'(parity_err), 32'(0));
`endif
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clear = 1'b0;
`ifdef RAM_SDP_CLR_PARITY_EN
    inj_err = 1'b0;
`endif
    @(posedge clock); @(posedge clock); #1;
    chk("reset_rd_data", 32'(rd_data), 32'(0));
    chk("reset_rd_valid", 32'(rd_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_clear_done", 32'(clear_done), 32'(0));
    reset = 1'b0;

    // we wa wd re ra exp_valid exp_data
    tbl[0] = '{1'b1, 6'd3,  8'hA5, 1'b0, 6'd0,  1'b0, 8'h00};
    tbl[1] = '{1'b1, 6'd7,  8'h11, 1'b1, 6'd3,  1'b1, 8'hA5};
    tbl[2] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  1'b0, 8'hA5};
    tbl[3] = '{1'b1, 6'd7,  8'h3C, 1'b1, 6'd7,  1'b1, 8'h11};
    tbl[4] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd7,  1'b1, 8'h3C};
    tbl[5] = '{1'b1, 6'd8,  8'h5A, 1'b1, 6'd3,  1'b1, 8'hA5};
    tbl[6] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd8,  1'b1, 8'h5A};
    tbl[7] = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  1'b0, 8'h5A};
    tbl[8] = '{1'b1, 6'd63, 8'hC3, 1'b1, 6'd8,  1'b1, 8'h5A};
    tbl[9] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd63, 1'b1, 8'hC3};

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      if (tbl[i].re) sb_q.push_back(tbl[i].exp_data);
      if (tbl[i].we) exp_mem[tbl[i].wa] = tbl[i].wd;
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      if (rd_valid) score($sformatf("tbl%0d_rd_data", i));
      else chk($sformatf("tbl%0d_rd_hold", i), 32'(rd_data), 32'(tbl[i].exp_data));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Full sweep with user traffic attempted mid-sweep.
    for (int a = 0; a < 64; a++) step(1'b1, 6'(a), 8'(a) ^ 8'h55, 1'b0, 6'd0);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'hEE; rd_en = 1'b1; rd_addr = 6'd3;
    @(posedge clock); #1;
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("sweep_busy_start", 32'(busy), 32'(1));
    chk("sweep_accept_rd_valid", 32'(rd_valid), 32'(0));
    n = 1;
    while (busy && n < 200) begin
      if (n == 5) begin
        wr_en = 1'b1; wr_addr = 6'd63; wr_data = 8'hFF; rd_en = 1'b1; rd_addr = 6'd0;
      end
      @(posedge clock); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      chk("sweep_rd_valid", 32'(rd_valid), 32'(0));
      if (busy) begin
        chk("sweep_done_early", 32'(clear_done), 32'(0));
        n++;
      end
    end
    chk("sweep_busy_cycles", 32'(n), 32'(64));
    chk("sweep_clear_done", 32'(clear_done), 32'(1));
    @(posedge clock); #1;
    chk("sweep_clear_done_width", 32'(clear_done), 32'(0));
    for (int a = 0; a < 64; a++) exp_mem[a] = 8'h00;
    for (int a = 0; a < 64; a++) step(1'b0, 6'd0, 8'h00, 1'b1, 6'(a));

    // Reset while sweeping: edges N+1..N+9 clear entries 0..8, reset on N+10.
    for (int a = 0; a < 64; a++) step(1'b1, 6'(a), 8'(a) ^ 8'h55, 1'b0, 6'd0);
    step(1'b0, 6'd0, 8'h00, 1'b1, 6'd20);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    for (int k = 1; k <= 9; k++) @(posedge clock);
    #1; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_clear_done", 32'(clear_done), 32'(0));
    chk("abort_rd_data", 32'(rd_data), 32'(0));
    for (int k = 0; k < 70; k++) begin
      @(posedge clock); #1;
      if (clear_done) chk("abort_no_done", 32'(clear_done), 32'(0));
    end
    chk("abort_still_idle", 32'(busy), 32'(0));
    for (int a = 0; a <= 8; a++) exp_mem[a] = 8'h00;
    for (int a = 0; a <= 8; a++) step(1'b0, 6'd0, 8'h00, 1'b1, 6'(a));
    step(1'b0, 6'd0, 8'h00, 1'b1, 6'd20);

    // Clear held high re-triggers on the first idle edge after clear_done.
    clear = 1'b1;
    for (int k = 0; k < 200 && !clear_done; k++) begin @(posedge clock); #1; end
    chk("retrig_first_done", 32'(clear_done), 32'(1));
    chk("retrig_idle_gap", 32'(busy), 32'(0));
    @(posedge clock); #1;
    clear = 1'b0;
    chk("retrig_busy_again", 32'(busy), 32'(1));
    for (int k = 0; k < 200 && busy; k++) begin @(posedge clock); #1; end
    chk("retrig_second_done", 32'(clear_done), 32'(1));
    for (int a = 0; a < 64; a++) exp_mem[a] = 8'h00;
    step(1'b0, 6'd0, 8'h00, 1'b1, 6'd20);
    step(1'b0, 6'd0, 8'h00, 1'b1, 6'd63);

`ifdef RAM_SDP_CLR_PARITY_EN
    // Injected parity fault is flagged on read, and cleared by a clean rewrite.
    inj_err = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h0F;
    @(posedge clock); #1;
    inj_err = 1'b0; wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd5;
    @(posedge clock); #1;
    rd_en = 1'b0;
    chk("par_inj_rd_data", 32'(rd_data), 32'(8'h0F));
    chk("par_inj_err", 32'(parity_err), 32'(1));
    @(posedge clock); #1;
    chk("par_err_idle", 32'(parity_err), 32'(0));
    exp_mem[5] = 8'h0F;
    step(1'b1, 6'd5, 8'h0F, 1'b0, 6'd0);
    step(1'b0, 6'd0, 8'h00, 1'b1, 6'd5);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, usable in the same cycle.
- Hardware clear engine sweeps every entry to a programmable value, with busy and done status.
- Registered read with a valid strobe.
- Used as the UART TX/RX buffer store and as a general scratch memory.

Parameters:
- WIDTH, 8: data bits per entry.
- ADDR_W, 6: address bits. DEPTH = 2**ADDR_W entries; DEPTH is a localparam, not overridable.
- CLEAR_VALUE, 0: WIDTH-bit value written to every entry by the clear sweep.

Ports:
- clock, input, 1: clock; all logic on its rising edge.
- reset, input, 1: synchronous reset, active-high.
- wr_en, input, 1: write strobe.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, WIDTH: write data.
- rd_en, input, 1: read strobe.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, WIDTH: registered read data.
- rd_valid, output, 1: one-cycle pulse; rd_data is valid this cycle.
- clear, input, 1: request a full-memory clear sweep.
- busy, output, 1: clear sweep in progress.
- clear_done, output, 1: one-cycle pulse when the sweep completes.
- parity_err, output, 1: PARITY_EN builds only; valid when rd_valid=1.
- inj_err, input, 1: PARITY_EN builds only; parity fault injection.

Behaviour:
- Reset (reset, synchronous, active-high; clock clock):
  - rd_data=0, rd_valid=0, busy=0, clear_done=0, parity_err=0.
  - Internal clear counter=0.
  - Array contents are not modified by reset.
- Reset mid-sweep aborts the sweep. Entries already cleared stay cleared; the rest keep their old contents; clear_done is not pulsed.
- Write, idle (busy=0, clear=0): at the edge with wr_en=1, mem[wr_addr]<=wr_data.
- Read, idle: at the edge with rd_en=1, rd_data<=mem[rd_addr] and rd_valid<=1. Latency is 1 cycle.
  - If rd_en=0, rd_valid<=0 and rd_data holds its last value.
- Read and write to the same address in the same cycle is read-first: rd_data returns the old contents. The new data is visible to a read issued the next cycle.
- Read and write to different addresses in the same cycle both complete.
- Address wrap: addresses are ADDR_W bits wide, so every value is a legal entry. No out-of-range case exists.
- Clear state machine has two states, IDLE and SWEEP.
  - IDLE -> SWEEP: at edge N with clear=1. busy<=1 and cnt<=0.
  - Any wr_en or rd_en in cycle N is dropped; clear has priority. rd_valid<=0 at edge N.
  - SWEEP: at each edge, mem[cnt]<=CLEAR_VALUE and cnt<=cnt+1. Edges N+1 through N+DEPTH write entries 0 through DEPTH-1.
  - SWEEP -> IDLE: at the edge writing entry DEPTH-1. busy<=0, clear_done<=1 for one cycle, cnt<=0.
  - Sweep length is DEPTH cycles after acceptance. busy is high for exactly DEPTH cycles.
- While busy=1:
  - wr_en and rd_en are ignored: no array write, rd_valid stays 0, rd_data holds.
  - clear is ignored; no restart and no queuing.
- clear held high continuously re-triggers a new sweep on the first idle edge after clear_done.
- clear_done is 0 on every cycle except the single completion cycle.

Optional Feature:
- Macro: RAM_SDP_CLR_PARITY_EN.
- Defined:
  - Each entry stores WIDTH+1 bits: data plus an even-parity bit (^wr_data).
  - The clear sweep stores the parity of CLEAR_VALUE.
  - parity_err is registered together with rd_data: 1 if the stored parity does not match the recomputed parity of the stored data. It is 0 whenever rd_valid=0.
  - inj_err=1 at a write inverts the stored parity bit for that write only.
- Undefined:
  - Array is WIDTH bits; parity_err and inj_err ports do not exist.
  - Behaviour is otherwise identical.

Test Plan:
- Write 0xA5 to addr 3, next cycle rd_en to addr 3 -> one cycle later rd_valid=1 and rd_data=0xA5. rd_valid is 0 on the following cycle with rd_en=0.
- Same cycle: wr addr 7 = 0x3C and rd addr 7, where addr 7 previously held 0x11 -> rd_data=0x11. A read of addr 7 next cycle -> 0x3C.
- Fill all 64 entries with addr^0x55, pulse clear (CLEAR_VALUE=0) -> busy=1 for exactly 64 cycles, then clear_done one-cycle pulse. Read every addr -> 0x00.
- During a sweep, issue wr addr 63 = 0xFF and rd addr 0 -> neither takes effect: rd_valid stays 0, and after the sweep addr 63 reads 0x00.
- Assert reset at sweep cycle 10 -> busy=0 next edge and no clear_done. Entries 0-8 read 0x00; entry 20 reads its pre-clear value.
- PARITY_EN: write 0x0F with inj_err=1 to addr 5, read addr 5 -> rd_data=0x0F and parity_err=1. Rewrite with inj_err=0 and read -> parity_err=0.
